// File: rtl/fpu_imem_loader.sv
// Instruction memory with a sequential program loader and a
// registered, fault-checking fetch port.
module fpu_imem_loader #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter int                ADDR_W = 32,
    parameter logic [DATA_W-1:0] FILL   = 32'h00000013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic              instr_fault,
    input  logic              resp_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     word_cnt;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              load_acc;
    logic              load_end;
    logic              fetch_acc;
    logic              fetch_fault;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL};

    assign load_ready = (state == LOAD);
    assign load_acc   = load_ready && load_valid;
    // A restart that carries a word in the same cycle writes it as word 0.
    assign wr_idx     = load_start ? '0 : word_cnt;
    assign load_end   = load_acc && (load_last || (&wr_idx));

    assign fetch_ready = (state == RUN) && (!instr_valid || resp_ready);
    assign fetch_acc   = fetch_req && fetch_ready;
    assign rd_idx      = fetch_addr[AW+1:2];
    assign fetch_fault = (|fetch_addr[1:0]) || (|fetch_addr[ADDR_W-1:AW+2]);

    always_comb begin
        state_next = state;
        case (state)
            RUN:  if (load_start) state_next = LOAD;
            LOAD: if (load_end) state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RUN;
            word_cnt  <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= load_end;
            if (load_acc) begin
                word_cnt <= (&wr_idx) ? wr_idx : wr_idx + AW'(1);
            end else if (load_start) begin
                word_cnt <= '0;
            end
        end
    end

    // Memory contents survive reset; only loads modify them.
    always_ff @(posedge clock) begin
        if (reset && load_acc) begin
            mem[wr_idx] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_fault <= 1'b0;
        end else if (state == RUN && load_start) begin
            instr_valid <= 1'b0;
        end else if (fetch_acc) begin
            instr_valid <= 1'b1;
            instr_fault <= fetch_fault;
            if (fetch_fault) begin
                instr <= FILL;
            end else begin
                instr <= mem[rd_idx];
            end
        end else if (resp_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_imem_loader.sv
// Directed bench for fpu_imem_loader with a response scoreboard
// fed by a reference memory model.
module tb_fpu_imem_loader;

    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam int          AW    = 32;
    localparam logic [31:0] FILL  = 32'h00000013;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic          instr_fault;
    logic          resp_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int resp_cnt = 0;
    int r0;

    logic [32:0] sb [$];
    logic [31:0] model [DEPTH];
    logic        acc_prev = 1'b0;
    logic [32:0] got;

    fpu_imem_loader #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .ADDR_W(AW),
        .FILL  (FILL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_fault(instr_fault),
        .resp_ready (resp_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] req_v);
        n_checks++;
        assert (obs === req_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req_v);
        end
    endtask

    function automatic logic [32:0] predict(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH))
            return {1'b1, FILL};
        return {1'b0, model[a[7:2]]};
    endfunction

    always @(negedge clock) begin
        if (acc_prev) check("latency", 64'(instr_valid), 64'd1);
        if (load_done) done_cnt++;
        if (instr_valid && resp_ready) begin
            resp_cnt++;
            check("resp_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                got = {instr_fault, instr};
                check("resp", 64'(got), 64'(sb.pop_front()));
            end
        end
        if (fetch_req && fetch_ready) sb.push_back(predict(fetch_addr));
        acc_prev = fetch_req && fetch_ready;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        int k;
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        k = 0;
        while (!fetch_ready && k < 20) begin
            tick();
            k++;
        end
        check("fetch_accept", 64'(fetch_ready), 64'd1);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic load_word(input logic [31:0] d, input logic last,
                             input int idx);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        check("load_ready", 64'(load_ready), 64'd1);
        tick();
        model[idx] = d;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = FILL;
        reset      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_fault", 64'(instr_fault), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        reset = 1'b1;

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_word(32'h1111_0001, 1'b0, 0);
        load_word(32'h1111_0002, 1'b0, 1);
        load_valid = 1'b1;
        load_data  = 32'h1111_0003;
        reset      = 1'b0;
        tick();
        reset      = 1'b1;
        load_valid = 1'b0;
        check("abort_load_ready", 64'(load_ready), 64'd0);
        tick();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        fetch(32'h0);
        fetch(32'h8);
        drain();

        // Three-word program
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_word(32'h002081B3, 1'b0, 0);
        load_word(32'h00000013, 1'b0, 1);
        load_word(32'hDEADBEEF, 1'b1, 2);
        check("done_pulse", 64'(load_done), 64'd1);
        check("done_run", 64'(load_ready), 64'd0);
        tick();
        check("done_width", 64'(load_done), 64'd0);
        fetch(32'h4);
        drain();

        // Faulting fetches
        fetch(32'h6);
        fetch(32'h100);
        drain();

        // Backpressure hold
        resp_ready = 1'b0;
        fetch(32'h8);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(instr_valid), 64'd1);
            check("hold_instr", 64'(instr), 64'hDEADBEEF);
            check("hold_fetch_ready", 64'(fetch_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("release_fetch_ready", 64'(fetch_ready), 64'd1);
        tick();
        drain();

        // Back-to-back fetches
        r0 = resp_cnt;
        for (int i = 0; i < 8; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(i * 4);
            #1;
            check("b2b_ready", 64'(fetch_ready), 64'd1);
            tick();
        end
        fetch_req = 1'b0;
        drain();
        check("b2b_count", 64'(resp_cnt - r0), 64'd8);

        // Full-depth load without load_last
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            load_word(32'hA500_0000 + 32'(i), 1'b0, i);
        check("full_done", 64'(load_done), 64'd1);
        check("full_run", 64'(load_ready), 64'd0);
        fetch(32'hFC);
        fetch(32'h0);
        drain();

        // load_start drops a held response
        resp_ready = 1'b0;
        fetch(32'h10);
        check("pend_valid", 64'(instr_valid), 64'd1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("drop_valid", 64'(instr_valid), 64'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        resp_ready = 1'b1;
        load_word(32'h1234_5678, 1'b1, 0);
        tick();
        fetch(32'h0);
        drain();

        check("done_count", 64'(done_cnt), 64'd3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_imem_loader.md
FPU_IMEM_LOADER -- requirements
Module: fpu_imem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of instruction words (power of 2, >= 2).
REQ-003 SHALL have parameter ADDR_W, default 32, meaning fetch byte-address width.
REQ-004 SHALL have parameter FILL, default 32'h00000013, meaning word returned on fault and power-up memory content.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning a synchronous, active-low reset.
REQ-007 SHALL have port load_start, input, 1, meaning a request to begin a program load at word 0.
REQ-008 SHALL have port load_valid, input, 1, meaning load_data is valid this cycle.
REQ-009 SHALL have port load_data, input, DATA_W, meaning the next sequential instruction word.
REQ-010 SHALL have port load_last, input, 1, meaning the current load word is the final one.
REQ-011 SHALL have port load_ready, output, 1, meaning the block accepts a load word this cycle.
REQ-012 SHALL have port load_done, output, 1, meaning a one-cycle pulse marking load completion.
REQ-013 SHALL have port fetch_req, input, 1, meaning a fetch request.
REQ-014 SHALL have port fetch_addr, input, ADDR_W, meaning the byte address of the requested instruction.
REQ-015 SHALL have port fetch_ready, output, 1, meaning a fetch is accepted when fetch_req is also 1.
REQ-016 SHALL have port instr_valid, output, 1, meaning instr and instr_fault are valid.
REQ-017 SHALL have port instr, output, DATA_W, meaning the fetched instruction word.
REQ-018 SHALL have port instr_fault, output, 1, meaning the fetch was misaligned or out of range.
REQ-019 SHALL have port resp_ready, input, 1, meaning the consumer takes the response this cycle.

Function
REQ-020 SHALL store DEPTH x DATA_W words, all initialised to FILL at time 0; reset SHALL NOT alter memory contents.
REQ-021 SHALL implement FSM states RUN and LOAD: RUN->LOAD on load_start; LOAD->RUN on an accepted word with load_last=1, or on acceptance of word index DEPTH-1.
REQ-022 load_start in LOAD SHALL restart the load with the word counter at 0.
REQ-023 In LOAD, load_ready SHALL be 1; an accepted word SHALL be written at index word_cnt, after which word_cnt increments (width clog2(DEPTH), no wrap past DEPTH-1).
REQ-024 load_done SHALL pulse for exactly one cycle, in the cycle after the final word is accepted (the first RUN cycle).
REQ-025 fetch_ready SHALL equal (state==RUN) && (!instr_valid || resp_ready); fetch_ready SHALL be 0 in LOAD.
REQ-026 An accepted fetch SHALL yield instr_valid=1 exactly one cycle later (registered read, 1-cycle latency).
REQ-027 The word index SHALL be fetch_addr[ADDR_W-1:2].
REQ-028 fault: fetch_addr[1:0]!=0 or index>=DEPTH; on fault the response SHALL be instr=FILL, instr_fault=1, with no memory read.
REQ-029 While instr_valid=1 and resp_ready=0, instr, instr_fault and instr_valid SHALL hold stable.
REQ-030 instr_valid SHALL clear when resp_ready=1 and no new fetch is accepted in the same cycle.
REQ-031 Back-to-back accepted fetches with resp_ready=1 SHALL give one response per cycle.
REQ-032 load_start in RUN SHALL drop any held response (instr_valid->0) in the next cycle.

Reset
REQ-033 On clock edge with reset=0: state=RUN, word_cnt=0, instr_valid=0, instr=0, instr_fault=0, load_done=0.
REQ-034 Reset mid-load SHALL abort the load; words already written SHALL remain; load_done SHALL NOT pulse.

Verification
REQ-035 Load 3 words 0x002081B3, 0x00000013, 0xDEADBEEF with load_last on the 3rd -> load_done pulses 1 cycle later; fetch 0x4 -> instr=0x00000013, instr_valid one cycle after acceptance.
REQ-036 Fetch 0x6 -> instr=FILL, instr_fault=1; fetch 0x100 (DEPTH=64) -> instr=FILL, instr_fault=1.
REQ-037 Response pending, resp_ready=0 for 3 cycles -> instr stable and fetch_ready=0; resp_ready=1 -> fetch_ready=1.
REQ-038 Load 64 words without load_last -> FSM returns to RUN after word 63; fetch 0xFC returns word 63.
REQ-039 reset=0 after 2 of 5 load words -> RUN, no load_done; fetch 0x0 returns the 1st loaded word, fetch 0x8 returns FILL.
REQ-040 fetch_req=1 every cycle for 8 cycles with resp_ready=1 -> 8 consecutive responses, addresses 0x0..0x1C in order.
